// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter
//   Two-master to one-slave AXI write arbiter. One write transaction is in
//   flight at a time. A four-state FSM walks IDLE -> AW -> W -> B. Arbitration
//   is round-robin on the last completed grant; after reset master 0 wins a tie.
//   The beat counter is loaded from awlen, so s_wlast is generated locally
//   rather than forwarded from the master.
//
//   Ports (master vectors: master 0 in the low slice, master 1 in the high slice)
//     aclk, areset                      clock, async active-high reset
//     m_aw{addr,len,valid} / m_awready  master address channels (32b/4b each)
//     m_w{data,strb,valid} / m_wready   master data channels (32b/4b each)
//     m_b{resp,valid} / m_bready        master response channels
//     s_aw{id,addr,len,valid}/s_awready slave address channel
//     s_w{data,strb,last,valid}/s_wready slave data channel
//     s_b{resp,valid} / s_bready        slave response channel
//     grant                             one-hot owner, 0 while idle
//   Optional (define AXI_WARB_STATS_EN):
//     grant_cnt0, grant_cnt1            saturating per-master grant counters
module axi_write_arbiter (
    input  logic        aclk,
    input  logic        areset,
    input  logic [63:0] m_awaddr,
    input  logic [7:0]  m_awlen,
    input  logic [1:0]  m_awvalid,
    output logic [1:0]  m_awready,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_wstrb,
    input  logic [1:0]  m_wvalid,
    output logic [1:0]  m_wready,
    output logic [3:0]  m_bresp,
    output logic [1:0]  m_bvalid,
    input  logic [1:0]  m_bready,
    output logic [3:0]  s_awid,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awlen,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready,
    output logic [1:0]  grant
`ifdef AXI_WARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t     state;
    logic       g;        // granted master index, meaningful while grant != 0
    logic       last;     // master granted by the last completed transaction
    logic [3:0] cnt;      // beats remaining after the current one
    logic       win;

    // Tie goes to the master that did not finish last; reset leaves last=1 so
    // master 0 wins the first tie.
    always_comb win = (&m_awvalid) ? ~last : m_awvalid[1];

    wire aw_hs = s_awvalid & s_awready;
    wire w_hs  = s_wvalid & s_wready;
    wire b_hs  = s_bvalid & s_bready;

    wire [3:0] sel_awlen = g ? m_awlen[7:4] : m_awlen[3:0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            g     <= 1'b0;
            last  <= 1'b1;
            cnt   <= 4'd0;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: if (|m_awvalid) begin
                    g     <= win;
                    grant <= win ? 2'b10 : 2'b01;
                    state <= AW;
                end
                AW: if (aw_hs) begin
                    cnt   <= sel_awlen;
                    state <= W;
                end
                W: if (w_hs) begin
                    if (cnt == 4'd0) state <= B;
                    else             cnt   <= cnt - 4'd1;
                end
                B: if (b_hs) begin
                    last  <= g;
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel muxing. Data fields follow the grant; valids/readies are only
    // opened in their own state so a stale grant can never leak a handshake.
    always_comb begin
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        m_bresp   = 4'd0;
        s_awid    = 4'd0;
        s_awaddr  = 32'd0;
        s_awlen   = 4'd0;
        s_awvalid = 1'b0;
        s_wdata   = 32'd0;
        s_wstrb   = 4'd0;
        s_wlast   = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        if (|grant) begin
            s_awid   = {3'b000, g};
            s_awaddr = g ? m_awaddr[63:32] : m_awaddr[31:0];
            s_awlen  = sel_awlen;
            s_wdata  = g ? m_wdata[63:32] : m_wdata[31:0];
            s_wstrb  = g ? m_wstrb[7:4] : m_wstrb[3:0];
        end
        case (state)
            AW: begin
                s_awvalid   = 1'b1;
                m_awready[g] = s_awready;
            end
            W: begin
                s_wvalid    = m_wvalid[g];
                s_wlast     = (cnt == 4'd0);
                m_wready[g] = s_wready;
            end
            B: begin
                s_bready    = m_bready[g];
                m_bvalid[g] = s_bvalid;
                m_bresp     = g ? {s_bresp, 2'b00} : {2'b00, s_bresp};
            end
            default: ;
        endcase
    end

`ifdef AXI_WARB_STATS_EN
    // Counted on the IDLE->AW transition, saturating.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (state == IDLE && (|m_awvalid)) begin
            if (win) begin
                if (grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
            end else begin
                if (grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            end
        end
    end
`endif

endmodule
